// File: rtl/fixed2float_sched_if.sv
`timescale 1ns/1ps
// fixed2float_sched_if
// Bundles the requester, converter and response signals of fixed2float_sched.
//   req_valid  [NUM_REQ]     per-requester request valid
//   req_fixed  [43*NUM_REQ]  per-requester signed operand, lane i at [43*i +: 43]
//   req_ready  [NUM_REQ]     per-requester accept, at most one bit high
//   conv_fixed [43]          registered operand towards the shared converter
//   conv_float [16]          converter result, CONV_LAT cycles after conv_fixed
//   resp_valid / resp_ready  result FIFO head handshake
//   resp_id    [ID_W]        requester index of the head result
//   resp_float [16]          half-precision result at the FIFO head
//   busy                     work in flight or results still queued
// The scheduler connects through the slave modport; the requester/consumer side
// uses the master modport.
interface fixed2float_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [43*NUM_REQ-1:0] req_fixed;
    logic [NUM_REQ-1:0]    req_ready;
    logic [42:0]           conv_fixed;
    logic [15:0]           conv_float;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [15:0]           resp_float;
    logic                  busy;

    modport slave (
        input  req_valid, req_fixed, conv_float, resp_ready,
        output req_ready, conv_fixed, resp_valid, resp_id, resp_float, busy
    );

    modport master (
        output req_valid, req_fixed, conv_float, resp_ready,
        input  req_ready, conv_fixed, resp_valid, resp_id, resp_float, busy
    );
endinterface

// File: rtl/fixed2float_sched.sv
`timescale 1ns/1ps
// fixed2float_sched
// Shares one external fixed-to-half converter between NUM_REQ requesters.
// A round-robin arbiter grants one request per cycle while FIFO credit exists,
// the winning operand is registered onto conv_fixed, a tag pipeline carries the
// requester id alongside the converter latency, and finished results land in a
// FIFO_DEPTH-entry result FIFO that drains in acceptance order.
// Ports:
//   r_clk      clock, rising edge
//   r_reset_n  synchronous active-low reset
//   bus        fixed2float_sched_if.slave (requests, converter, responses, busy)
// Build option:
//   F2F_SCHED_PRIO_EN  when defined, requester 0 has strict priority over the
//                      round-robin among the other requesters.
module fixed2float_sched #(
    parameter int NUM_REQ    = 4,
    parameter int CONV_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               r_clk,
    input  logic               r_reset_n,
    fixed2float_sched_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = ID_W + 16;

    logic [ID_W-1:0]     rr_ptr;
    logic [42:0]         conv_fixed_q;
    logic                issue_valid;
    logic [ID_W-1:0]     issue_id;
    logic [CONV_LAT-1:0] tag_valid;
    logic [ID_W-1:0]     tag_id [CONV_LAT];
    logic [CNT_W-1:0]    inflight_count;
    logic [CNT_W-1:0]    fifo_count;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];

    logic [CNT_W:0]      occupancy;
    logic                credit_ok;
    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     cand_idx;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [42:0]         sel_fixed;
    logic                accept;
    logic                rr_hold;
    logic [ID_W-1:0]     rr_next;
    logic                push;
    logic                pop;
    logic [ENT_W-1:0]    head;
    logic                resp_valid_int;

    // Credit counts both queued results and operations still inside the
    // converter, so every accepted request is guaranteed a FIFO slot. A pop in
    // the current cycle deliberately does not free credit until it has happened.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_count};
    assign credit_ok = (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    // Arbiter: scan from rr_ptr upwards, wrapping, and stop at the first valid
    // requester. With the priority option, requester 0 preempts the scan; the
    // scan itself still skips 0 naturally when it is not requesting.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
`ifdef F2F_SCHED_PRIO_EN
        if (bus.req_valid[0]) begin
            grant_found = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign accept = r_reset_n && credit_ok && grant_found;

    // A priority grant to requester 0 must not disturb the rotation among the
    // remaining requesters.
`ifdef F2F_SCHED_PRIO_EN
    assign rr_hold = (grant_idx == '0);
`else
    assign rr_hold = 1'b0;
`endif

    assign rr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Expand the winner into the one-hot ready vector and pick its operand.
    always_comb begin
        grant_onehot = '0;
        sel_fixed    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot[i] = accept && (grant_idx == ID_W'(i));
            if (grant_onehot[i]) begin
                sel_fixed = bus.req_fixed[43*i +: 43];
            end
        end
    end

    assign push = tag_valid[CONV_LAT-1];
    assign pop  = resp_valid_int && bus.resp_ready;

    // Control state. issue_valid marks the cycle conv_fixed carries a fresh
    // operand; the tag_valid chain then tracks that operand through the
    // CONV_LAT converter stages so its last stage lines up with conv_float.
    // inflight_count covers the issue register plus the tag chain.
    always_ff @(posedge r_clk) begin
        if (!r_reset_n) begin
            rr_ptr         <= '0;
            conv_fixed_q   <= '0;
            issue_valid    <= 1'b0;
            issue_id       <= '0;
            tag_valid      <= '0;
            inflight_count <= '0;
            fifo_count     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
        end else begin
            issue_valid <= accept;
            if (accept) begin
                conv_fixed_q <= sel_fixed;
                issue_id     <= grant_idx;
                if (!rr_hold) begin
                    rr_ptr <= rr_next;
                end
            end

            tag_valid[0] <= issue_valid;
            for (int k = 1; k < CONV_LAT; k++) begin
                tag_valid[k] <= tag_valid[k-1];
            end

            case ({accept, push})
                2'b10:   inflight_count <= inflight_count + 1'b1;
                2'b01:   inflight_count <= inflight_count - 1'b1;
                default: inflight_count <= inflight_count;
            endcase

            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Datapath storage needs no reset: the valid bits above decide whether any
    // of it is ever looked at.
    always_ff @(posedge r_clk) begin
        tag_id[0] <= issue_id;
        for (int k = 1; k < CONV_LAT; k++) begin
            tag_id[k] <= tag_id[k-1];
        end
        if (push) begin
            fifo_mem[wr_ptr] <= {tag_id[CONV_LAT-1], bus.conv_float};
        end
    end

    // Outputs are forced to zero while in reset or when the FIFO is empty, so
    // stale FIFO contents never show on resp_id/resp_float.
    assign head           = fifo_mem[rd_ptr];
    assign resp_valid_int = r_reset_n && (fifo_count != '0);

    assign bus.req_ready  = grant_onehot;
    assign bus.conv_fixed = conv_fixed_q;
    assign bus.resp_valid = resp_valid_int;
    assign bus.resp_id    = resp_valid_int ? head[ENT_W-1:16] : '0;
    assign bus.resp_float = resp_valid_int ? head[15:0] : '0;
    assign bus.busy       = r_reset_n && ((inflight_count != '0) || (fifo_count != '0));
endmodule

// File: tb/tb_fixed2float_sched.sv
`timescale 1ns/1ps
// tb_fixed2float_sched
// Drives fixed2float_sched with a behavioural two-stage fixed-to-half converter
// (43-bit signed operand with 25 fraction bits, truncating) and checks grants,
// latency, ids and results against hand-computed values, plus the credit,
// backpressure and mid-operation reset corner cases.
module tb_fixed2float_sched;
    localparam int          NUM_REQ    = 4;
    localparam int          CONV_LAT   = 2;
    localparam int          FIFO_DEPTH = 4;
    localparam int          NVEC       = 8;
    localparam logic [42:0] DECOY      = 43'h400_0000;

    typedef struct {
        logic [3:0]  valid;
        logic [42:0] operand;
        int          grant;
        logic [15:0] expf;
    } vec_t;

`ifdef F2F_SCHED_PRIO_EN
    localparam int EXP_G [NVEC] = '{1, 0, 0, 0, 3, 0, 0, 0};
    localparam int EXP_A [5]    = '{0, 0, 0, 0, 0};
`else
    localparam int EXP_G [NVEC] = '{1, 2, 0, 3, 3, 0, 2, 0};
    localparam int EXP_A [5]    = '{0, 1, 2, 3, 0};
`endif
    localparam int          EXP_B  [3] = '{1, 2, 3};
    localparam logic [15:0] LANE_F [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};

    logic        r_clk = 1'b0;
    logic        r_reset_n;
    logic [15:0] conv_s1;
    logic [15:0] conv_s2;
    int          total = 0;
    int          bad   = 0;
    vec_t        vecs [NVEC];
    int          grants [$];
    int          resp_ids [$];
    logic [15:0] resp_fl [$];

    fixed2float_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    fixed2float_sched #(
        .NUM_REQ   (NUM_REQ),
        .CONV_LAT  (CONV_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .r_clk    (r_clk),
        .r_reset_n(r_reset_n),
        .bus      (bus)
    );

    always #5 r_clk = ~r_clk;

    // Reference fixed-to-half conversion: value = x * 2^-25, truncated.
    function automatic logic [15:0] to_half(input logic [42:0] x);
        logic        sgn;
        logic [43:0] mag;
        logic [43:0] shifted;
        int          p;
        int          biased;
        sgn = x[42];
        mag = sgn ? (44'd0 - {x[42], x}) : {1'b0, x};
        p = -1;
        for (int b = 0; b < 44; b++) begin
            if (mag[b]) p = b;
        end
        if (p < 0) return {sgn, 15'd0};
        biased = p - 10;
        if (biased >= 31) return {sgn, 5'h1F, 10'd0};
        if (biased <= 0) begin
            shifted = mag >> 1;
            return {sgn, 5'd0, shifted[9:0]};
        end
        shifted = mag >> (p - 10);
        return {sgn, biased[4:0], shifted[9:0]};
    endfunction

    // Two-register converter model, so conv_float trails conv_fixed by CONV_LAT.
    always @(posedge r_clk) begin
        conv_s1 <= to_half(bus.conv_fixed);
        conv_s2 <= conv_s1;
    end
    assign bus.conv_float = conv_s2;

    function automatic int onehot_to_idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic do_reset();
        r_reset_n     = 1'b0;
        bus.req_valid = '0;
        @(posedge r_clk);
        @(posedge r_clk);
        #1;
        r_reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int cnt;
        cnt = 0;
        while (bus.busy && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput(name, bus.busy, 0);
    endtask

    task automatic set_lanes();
        for (int l = 0; l < NUM_REQ; l++) begin
            bus.req_fixed[43*l +: 43] = 43'((l + 1)) << 25;
        end
    endtask

    // One vector: a single-cycle request, then follow it to the FIFO head.
    task automatic applyStimulus(input int idx, input vec_t v);
        logic [3:0] oh;
        int         lat;
        oh = 4'b0001 << v.grant;
        bus.req_valid = v.valid;
        for (int l = 0; l < NUM_REQ; l++) begin
            bus.req_fixed[43*l +: 43] = (l == v.grant) ? v.operand : DECOY;
        end
        @(negedge r_clk);
        checkOutput($sformatf("vec%0d_ready", idx), bus.req_ready, oh);
        tick();
        bus.req_valid = '0;
        lat = 0;
        while (!bus.resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        checkOutput($sformatf("vec%0d_latency", idx), lat, 3);
        checkOutput($sformatf("vec%0d_id", idx), bus.resp_id, v.grant);
        checkOutput($sformatf("vec%0d_float", idx), bus.resp_float, v.expf);
        wait_idle($sformatf("vec%0d_idle", idx));
    endtask

    // Hold a request pattern until n grants are seen, logging grants and pops.
    task automatic run_grants(input logic [3:0] pattern, input int n, input int nresp);
        grants.delete();
        resp_ids.delete();
        resp_fl.delete();
        bus.req_valid = pattern;
        for (int c = 0; c < 40 && (grants.size() < n || resp_ids.size() < nresp); c++) begin
            @(negedge r_clk);
            if (bus.req_ready != '0) grants.push_back(onehot_to_idx(bus.req_ready));
            if (bus.resp_valid && bus.resp_ready) begin
                resp_ids.push_back(int'(bus.resp_id));
                resp_fl.push_back(bus.resp_float);
            end
            tick();
            if (grants.size() >= n) bus.req_valid = '0;
        end
        bus.req_valid = '0;
    endtask

    initial begin
        int accepts;
        int pop_cyc;
        int acc_cyc;
        int seen;

        vecs[0] = '{4'b0010, 43'h800,         EXP_G[0], 16'h0400};
        vecs[1] = '{4'b1111, 43'h300_0000,    EXP_G[1], 16'h3E00};
        vecs[2] = '{4'b0011, 43'h7FF_FE00_0000, EXP_G[2], 16'hBC00};
        vecs[3] = '{4'b1001, 43'h100,         EXP_G[3], 16'h0080};
        vecs[4] = '{4'b1000, 43'h200_0000_0000, EXP_G[4], 16'h7C00};
        vecs[5] = '{4'b0101, 43'h0,           EXP_G[5], 16'h0000};
        vecs[6] = '{4'b0101, 43'h200_0000,    EXP_G[6], 16'h3C00};
        vecs[7] = '{4'b0001, 43'h300_0000,    EXP_G[7], 16'h3E00};

        r_reset_n      = 1'b0;
        bus.req_valid  = 4'b1111;
        bus.req_fixed  = '0;
        bus.resp_ready = 1'b1;
        @(posedge r_clk);
        @(posedge r_clk);
        @(negedge r_clk);
        checkOutput("rst_req_ready", bus.req_ready, 0);
        checkOutput("rst_resp_valid", bus.resp_valid, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_resp_id", bus.resp_id, 0);
        checkOutput("rst_resp_float", bus.resp_float, 0);
        checkOutput("rst_conv_fixed", bus.conv_fixed, 0);
        tick();
        bus.req_valid = '0;
        r_reset_n     = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i, vecs[i]);
        end

        $display("[TB] all-requesters rotation from reset");
        do_reset();
        set_lanes();
        run_grants(4'b1111, 5, 5);
        checkOutput("seqA_grant_count", grants.size(), 5);
        for (int k = 0; k < grants.size() && k < 5; k++) begin
            checkOutput($sformatf("seqA_grant%0d", k), grants[k], EXP_A[k]);
        end
        checkOutput("seqA_resp_count", resp_ids.size(), 5);
        for (int k = 0; k < resp_ids.size() && k < 5; k++) begin
            checkOutput($sformatf("seqA_resp_id%0d", k), resp_ids[k], EXP_A[k]);
            checkOutput($sformatf("seqA_resp_float%0d", k), resp_fl[k], LANE_F[EXP_A[k]]);
        end
        wait_idle("seqA_idle");

        run_grants(4'b1110, 3, 0);
        checkOutput("seqB_grant_count", grants.size(), 3);
        for (int k = 0; k < grants.size() && k < 3; k++) begin
            checkOutput($sformatf("seqB_grant%0d", k), grants[k], EXP_B[k]);
        end
        wait_idle("seqB_idle");

        $display("[TB] credit exhaustion under backpressure");
        do_reset();
        set_lanes();
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b1111;
        accepts = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge r_clk);
            if (bus.req_ready != '0) accepts++;
            tick();
        end
        @(negedge r_clk);
        checkOutput("seqC_accepts", accepts, 4);
        checkOutput("seqC_ready_blocked", bus.req_ready, 0);
        checkOutput("seqC_resp_valid", bus.resp_valid, 1);
        tick();
        bus.resp_ready = 1'b1;
        pop_cyc = -1;
        acc_cyc = -1;
        for (int c = 0; c < 10 && acc_cyc < 0; c++) begin
            @(negedge r_clk);
            if (pop_cyc < 0 && bus.resp_valid && bus.resp_ready) begin
                pop_cyc = c;
                checkOutput("seqC_first_pop_id", bus.resp_id, 0);
            end
            if (pop_cyc >= 0 && bus.req_ready != '0) acc_cyc = c;
            tick();
        end
        checkOutput("seqC_pop_cycle", pop_cyc, 0);
        checkOutput("seqC_resume_cycle", acc_cyc, 1);
        bus.req_valid = '0;
        wait_idle("seqC_idle");

        $display("[TB] reset with operations in flight");
        do_reset();
        bus.req_valid = 4'b1111;
        tick();
        tick();
        bus.req_valid = '0;
        checkOutput("seqD_busy_before", bus.busy, 1);
        r_reset_n = 1'b0;
        tick();
        r_reset_n = 1'b1;
        @(negedge r_clk);
        checkOutput("seqD_busy_after", bus.busy, 0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge r_clk);
            if (bus.resp_valid) seen++;
        end
        checkOutput("seqD_no_resp", seen, 0);
        tick();
        bus.req_valid = 4'b1111;
        @(negedge r_clk);
        checkOutput("seqD_next_grant", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fixed2float_sched.md
FIXED2FLOAT_SCHED -- requirements
Module: fixed2float_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one fixed2float converter.
REQ-002 SHALL have parameter CONV_LAT, default 2, converter latency in cycles from conv_fixed to matching conv_float.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries, power of two.
REQ-004 SHALL have port r_clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port r_reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port req_fixed  input  43*NUM_REQ  per-requester signed fixed-point operand; requester i occupies bits [43*i+42 : 43*i].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-009 SHALL have port conv_fixed  output  43  registered operand to converter fixed_in.
REQ-010 SHALL have port conv_float  input  16  converter float_out.
REQ-011 SHALL have port resp_valid  output  1  FIFO head valid.
REQ-012 SHALL have port resp_ready  input  1  consumer accept.
REQ-013 SHALL have port resp_id  output  $clog2(NUM_REQ)  requester index of head result.
REQ-014 SHALL have port resp_float  output  16  half-precision result at head.
REQ-015 SHALL have port busy  output  1  high while any operation is in flight or the FIFO is non-empty.

Function
REQ-016 SHALL accept a request from requester i on an edge where req_valid[i] and req_ready[i] are both high; at most one acceptance per cycle.
REQ-017 SHALL drive req_ready combinationally: one-hot to the first valid requester at or after rr_ptr (wrapping NUM_REQ-1 -> 0), all-zero when credit is unavailable.
REQ-018 SHALL advance rr_ptr to (granted index + 1) mod NUM_REQ on acceptance and leave it unchanged otherwise.
REQ-019 SHALL have credit available iff fifo_count + inflight_count < FIFO_DEPTH, evaluated on current-cycle registered values; a same-cycle pop does not grant credit.
REQ-020 SHALL register the accepted operand into conv_fixed on the acceptance edge and hold conv_fixed when idle.
REQ-021 SHALL carry a valid bit and requester id through a CONV_LAT-deep tag shift register aligned with conv_float.
REQ-022 SHALL write {id, conv_float} into the FIFO on the edge where the tag pipeline output is valid.
REQ-023 SHALL, with an empty FIFO, assert resp_valid CONV_LAT+1 edges after the acceptance edge (3 with defaults).
REQ-024 SHALL pop the FIFO when resp_valid and resp_ready are both high; resp_id/resp_float SHALL stay stable while resp_valid is high and resp_ready is low.
REQ-025 SHALL leave fifo_count unchanged on a simultaneous push and pop, and never overflow, since credit guarantees space.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-027 SHALL keep inflight_count equal to the number of valid tag stages (increment on accept, decrement on FIFO write; unchanged if both occur).
REQ-028 SHALL deliver results in acceptance order.

Reset
REQ-029 SHALL, while r_reset_n is low at a rising edge, clear rr_ptr, tag valids, inflight_count, fifo_count, and FIFO pointers, and set conv_fixed to 0.
REQ-030 SHALL hold req_ready, resp_valid, and busy at 0 during reset; resp_id and resp_float SHALL read 0.
REQ-031 SHALL discard operations in flight when reset is asserted mid-operation, with no response produced after reset release.

Configuration
REQ-032 SHALL, when macro F2F_SCHED_PRIO_EN is defined, give requester 0 strict priority: grant 0 whenever req_valid[0] and credit are present, apply round-robin among the others otherwise, and leave rr_ptr unchanged on a grant to 0.
REQ-033 SHALL, without F2F_SCHED_PRIO_EN, use pure round-robin per REQ-017/018.

Verification
REQ-034 SHALL cover: requester 1 alone sends 43'h800 with the real converter, resp_ready=1 -> resp_valid 3 edges later, resp_id=1, resp_float=16'h0400.
REQ-035 SHALL cover: all four req_valid held high from reset -> grant sequence 0,1,2,3,0, and responses in the same id order.
REQ-036 SHALL cover: resp_ready=0 with continuous requests -> exactly 4 acceptances, then req_ready=0; after resp_ready=1, acceptances resume one cycle after the first pop.
REQ-037 SHALL cover: reset pulsed low for one cycle with 2 operations in flight -> busy=0 and no resp_valid afterwards; the next grant goes to requester 0.
REQ-038 SHALL cover: with F2F_SCHED_PRIO_EN, req_valid=4'b1111 held -> requester 0 is granted every cycle while credit lasts; with req_valid=4'b1110, grants rotate 1,2,3.
